// File: rtl/syzygy_adc_pkg.sv
// syzygy_adc_pkg: frame-capture FSM states, default widths and offset-binary conversion.
package syzygy_adc_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_ADDR_W = 8;
  // Offset binary to two's complement is a flip of the sign bit at width w.
  function automatic logic [31:0] ob_to_tc(input logic [31:0] d, input int w);
    return d ^ (32'd1 << (w - 1));
  endfunction
endpackage

// File: rtl/syzygy_adc_frame_ram.sv
// syzygy_adc_frame_ram: simple dual-port frame buffer, one write port, registered read-first read port.
module syzygy_adc_frame_ram
  import syzygy_adc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [0:2**ADDR_W-1];
  logic [DATA_W-1:0] r_q;
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  // Only the output register is reset; the array itself stays uninitialised.
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_q <= '0;
    else if (i_re) r_q <= r_mem[i_raddr];
  assign o_rdata = r_q;
endmodule

// File: rtl/syzygy_adc_frame_capture.sv
// syzygy_adc_frame_capture: arms on a pulse, captures one 2**ADDR_W sample ADC frame for an FFT reader.
// Define SYZYGY_ADC_TRIGGER_EN to wait for a rising crossing of trig_level instead of the first valid sample.
module syzygy_adc_frame_capture
  import syzygy_adc_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter bit TWOS_COMP = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              adc_valid,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [ADDR_W-1:0] fft_addr,
  input  logic              fft_rd_en,
  output logic [DATA_W-1:0] fft_data_o,
  output logic              frame_ready,
  output logic              busy,
  output logic [ADDR_W:0]   wr_count
);
  localparam logic [ADDR_W:0] N = (ADDR_W+1)'(2**ADDR_W);
  state_t r_state, w_next;
  logic [ADDR_W:0] r_cnt;
  logic [DATA_W-1:0] w_sample;
  logic w_trig, w_we;
  assign w_sample = TWOS_COMP ? DATA_W'(ob_to_tc(32'(adc_data_i), DATA_W)) : adc_data_i;
`ifdef SYZYGY_ADC_TRIGGER_EN
  logic [DATA_W-1:0] r_hist;
  logic r_hist_vld;
  assign w_trig = adc_valid && r_hist_vld && ($signed(r_hist) < $signed(trig_level))
                  && ($signed(w_sample) >= $signed(trig_level));
  // History is invalidated outside ARMED so the first sample after arming can only seed it.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_hist <= '0;
      r_hist_vld <= 1'b0;
    end else if (r_state != ARMED) r_hist_vld <= 1'b0;
    else if (adc_valid) begin
      r_hist <= w_sample;
      r_hist_vld <= 1'b1;
    end
`else
  logic unused_trig;
  assign unused_trig = ^trig_level;
  assign w_trig = adc_valid;
`endif
  always_comb begin
    w_next = r_state;
    w_we = 1'b0;
    case (r_state)
      IDLE, DONE: w_next = arm ? ARMED : r_state;
      ARMED: begin
        w_we = w_trig;
        w_next = w_trig ? CAPTURE : ARMED;
      end
      CAPTURE: begin
        w_we = adc_valid;
        w_next = (adc_valid && r_cnt == N - 1'b1) ? DONE : CAPTURE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_next == ARMED && r_state != ARMED) ? '0 : r_cnt + (ADDR_W+1)'(w_we);
    end
  assign frame_ready = r_state == DONE;
  assign busy = r_state == ARMED || r_state == CAPTURE;
  assign wr_count = r_cnt;
  syzygy_adc_frame_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (r_cnt[ADDR_W-1:0]),
    .i_wdata (w_sample),
    .i_re    (fft_rd_en),
    .i_raddr (fft_addr),
    .o_rdata (fft_data_o)
  );
endmodule
